// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state types for the UART program loader.
// Included by the receiver front end and by the frame sequencer.
package uart_prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StChk} frame_state_e;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start-glitch rejection.
// Emits a one-cycle byte_valid (or frame_err on a bad stop bit) after the stop sample.
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);

  rx_state_e       st_q, st_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_s, fall, tick;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  assign tick = (cnt_q == BitLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= RxIdle;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      RxIdle:  if (fall) st_d = RxStart;
      // A start bit that reads high at mid-bit was only a glitch.
      RxStart: if (cnt_q == HalfBit) st_d = rx_s ? RxIdle : RxData;
      RxData:  if (tick && bit_q == 3'd7) st_d = RxStop;
      RxStop:  if (tick) st_d = RxIdle;
      default: st_d = RxIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (st_q)
      RxIdle:  cnt_d = '0;
      RxStart: if (cnt_q == HalfBit) begin
        cnt_d = '0;
        bit_d = '0;
      end
      RxData:  if (tick) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
      end
      RxStop:  if (tick) begin
        cnt_d   = '0;
        valid_d = rx_s;
        ferr_d  = ~rx_s;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      prev_q  <= rx_s;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign rx_byte    = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: parses A5/ADDR/LEN/data/CHK frames from a UART line and writes
// each data byte into instruction memory, holding the CPU in reset while a frame is open.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] inst_address,
  output logic [7:0]        inst_data,
  output logic              inst_we,
  output logic              cpu_hold,
  output logic              load_ok,
  output logic              load_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TmoW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_BITS);

  logic       byte_valid, frame_err, timeout;
  logic [7:0] rx_byte;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  frame_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d, sum_q, sum_d, data_q, data_d;
  logic              we_q, we_d, hold_q, hold_d, ok_q, ok_d, err_q, err_d;
  logic [CntW-1:0]   tclk_q, tclk_d;
  logic [TmoW-1:0]   tbits_q, tbits_d;

  assign timeout = (state_q != StIdle) && (tbits_q == TmoLimit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // An arriving byte takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (frame_err) begin
      state_d = StIdle;
    end else if (byte_valid) begin
      unique case (state_q)
        StIdle:  if (rx_byte == SYNC_BYTE) state_d = StAddr;
        StAddr:  state_d = StLen;
        StLen:   state_d = (rx_byte == 8'd0) ? StChk : StData;
        StData:  if (cnt_q == 8'd1) state_d = StChk;
        StChk:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end else if (timeout) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d   = 1'b0;
    ok_d   = 1'b0;
    hold_d = hold_q;
    err_d  = err_q;
    if (frame_err) begin
      if (state_q != StIdle) err_d = 1'b1;
    end else if (byte_valid) begin
      unique case (state_q)
        StIdle: if (rx_byte == SYNC_BYTE) begin
          hold_d = 1'b1;
          err_d  = 1'b0;
          sum_d  = 8'd0;
        end
        StAddr: begin
          ptr_d = rx_byte[ADDR_W-1:0];
          sum_d = sum_q + rx_byte;
        end
        StLen: begin
          cnt_d = rx_byte;
          sum_d = sum_q + rx_byte;
        end
        StData: begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = rx_byte;
          ptr_d  = ptr_q + 1'b1;
          sum_d  = sum_q + rx_byte;
          cnt_d  = cnt_q - 8'd1;
        end
        StChk: begin
          if (rx_byte == sum_q) begin
            ok_d   = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    tclk_d  = tclk_q + 1'b1;
    tbits_d = tbits_q;
    if (state_q == StIdle || byte_valid || timeout) begin
      tclk_d  = '0;
      tbits_d = '0;
    end else if (tclk_q == BitLast) begin
      tclk_d  = '0;
      tbits_d = tbits_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      tclk_q  <= '0;
      tbits_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      tclk_q  <= tclk_d;
      tbits_q <= tbits_d;
    end
  end

  assign inst_address = addr_q;
  assign inst_data    = data_q;
  assign inst_we      = we_q;
  assign cpu_hold     = hold_q;
  assign load_ok      = ok_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed frames, error cases and randomized frames
// checked against a frame-level reference model of expected memory writes.
module tb_uart_prog_loader;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [6:0] inst_address;
  logic [7:0] inst_data;
  logic       inst_we, cpu_hold, load_ok, load_err;

  int checks = 0;
  int failures = 0;
  int ok_cnt = 0;
  int bv_cnt = 0;
  int pulse_viol = 0;
  logic we_prev = 1'b0;
  logic ok_prev = 1'b0;
  logic [14:0] wq[$];
  logic [7:0]  dq[$];

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (7),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .inst_address(inst_address),
    .inst_data   (inst_data),
    .inst_we     (inst_we),
    .cpu_hold    (cpu_hold),
    .load_ok     (load_ok),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inst_we) wq.push_back({inst_address, inst_data});
    if ((inst_we && we_prev) || (load_ok && ok_prev)) pulse_viol++;
    if (load_ok) ok_cnt++;
    if (dut.byte_valid) bv_cnt++;
    we_prev = inst_we;
    ok_prev = load_ok;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, inst_address, 0);
    check({tag, "_data"}, inst_data, 0);
    check({tag, "_we"}, inst_we, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_ok"}, load_ok, 0);
    check({tag, "_err"}, load_err, 0);
  endtask

  // Sends A5, addr, len=dq.size(), dq bytes, checksum; chk_xor != 0 corrupts the checksum.
  task automatic run_frame(input string tag, input logic [7:0] addr, input logic [7:0] chk_xor);
    logic [7:0]  sum;
    logic [14:0] exp[$];
    int          ok0;
    int          n;
    logic        good;
    n    = dq.size();
    sum  = 8'((int'(addr) + n) % 256);
    good = (chk_xor == 8'd0);
    for (int i = 0; i < n; i++) begin
      sum = 8'((int'(sum) + int'(dq[i])) % 256);
      exp.push_back({7'((int'(addr) + i) % 128), dq[i]});
    end
    wq.delete();
    ok0 = ok_cnt;
    send_byte(8'hA5, 1'b1);
    #1 check({tag, "_hold_sync"}, cpu_hold, 1);
    send_byte(addr, 1'b1);
    send_byte(8'(n), 1'b1);
    for (int i = 0; i < n; i++) send_byte(dq[i], 1'b1);
    #1 check({tag, "_hold_prechk"}, cpu_hold, 1);
    send_byte(sum ^ chk_xor, 1'b1);
    settle();
    check({tag, "_nwr"}, wq.size(), exp.size());
    for (int i = 0; i < n && i < wq.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wq[i], exp[i]);
    check({tag, "_ok"}, ok_cnt - ok0, good ? 1 : 0);
    check({tag, "_err"}, load_err, good ? 0 : 1);
    check({tag, "_hold"}, cpu_hold, good ? 0 : 1);
  endtask

  initial begin
    int bv0;
    int ok0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Stray bytes before any sync are received but ignored.
    wq.delete();
    bv0 = bv_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    settle();
    check("stray_bv", bv_cnt - bv0, 2);
    check("stray_nwr", wq.size(), 0);
    check("stray_hold", cpu_hold, 0);

    dq.delete(); dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33);
    run_frame("f1", 8'h10, 8'h00);

    dq.delete(); dq.push_back(8'hAA); dq.push_back(8'hBB);
    run_frame("wrap", 8'h7F, 8'h00);

    // Correct checksum is 0x56; sending 0x00 must fail.
    dq.delete(); dq.push_back(8'h55);
    run_frame("badchk", 8'h00, 8'h56);

    dq.delete(); dq.push_back(8'h01);
    run_frame("recover", 8'h05, 8'h00);

    // Idle line mid-frame: still open at 30 bit-times, aborted by 34.
    wq.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (30 * CPB) @(posedge clk);
    #1 check("tmo_early_err", load_err, 0);
    repeat (4 * CPB) @(posedge clk);
    #1 check("tmo_err", load_err, 1);
    check("tmo_hold", cpu_hold, 1);
    check("tmo_nwr", wq.size(), 0);
    // Back in IDLE: a following byte is not taken as LEN/data.
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    settle();
    check("tmo_idle_nwr", wq.size(), 0);

    // Bad stop bit on a data byte drops it and aborts the frame.
    wq.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h44, 1'b0);
    settle();
    check("stop_nwr", wq.size(), 0);
    check("stop_err", load_err, 1);
    check("stop_hold", cpu_hold, 1);
    send_byte(8'h55, 1'b1);
    settle();
    check("stop_after_nwr", wq.size(), 0);

    // Quarter-bit low glitch in IDLE.
    bv0 = bv_cnt;
    rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1 check("glitch_bv", bv_cnt - bv0, 0);

    dq.delete(); dq.push_back(8'h9C);
    run_frame("post_glitch", 8'h60, 8'h00);

    // Asynchronous reset in the middle of DATA.
    wq.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1);
    settle();
    check("mid_nwr", wq.size(), 1);
    check("mid_hold", cpu_hold, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wq.delete();
    ok0 = ok_cnt;
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h49, 1'b1);
    settle();
    check("post_rst_nwr", wq.size(), 0);
    check("post_rst_ok", ok_cnt - ok0, 0);
    check("post_rst_hold", cpu_hold, 0);

    dq.delete();
    run_frame("len0", 8'h33, 8'h00);

    for (int f = 0; f < 4; f++) begin
      logic [7:0] a;
      logic [7:0] x;
      int         len;
      a   = 8'($urandom_range(0, 255));
      len = $urandom_range(0, 5);
      x   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      dq.delete();
      for (int i = 0; i < len; i++) dq.push_back(8'($urandom_range(0, 255)));
      run_frame($sformatf("rand%0d", f), a, x);
    end

    check("pulse_width", pulse_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
